// File: rtl/cache_pkg.sv
// Shared types, arbitration codes and width helpers for the write-back cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_EVICT = 2'd2,
    D_FILL  = 2'd3
  } state_t;

  localparam int ARB_DFIRST = 0;
  localparam int ARB_IFIRST = 1;
  localparam int ARB_RR     = 2;

  // Derived widths for the default configuration (16-bit words, 4-word lines, 6 index bits)
  localparam int OFF_W  = 2;
  localparam int LINE_W = 64;
  localparam int TAG_W  = 8;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int line_w(input int word_w, input int line_words);
    return word_w * line_words;
  endfunction

  function automatic int tag_w(input int addr_w, input int idx_w, input int line_words);
    return addr_w - idx_w - $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_ctrl_wb_line_word.sv
// Word select and single-word merge on a cache line.
module line_word #(
  parameter  int WORD_W     = 16,
  parameter  int LINE_WORDS = 4,
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int LINE_W     = WORD_W * LINE_WORDS
) (
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  offset,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] merged
);

  // Extract the addressed word and build the line with that word replaced
  always_comb begin
    word   = line[offset*WORD_W +: WORD_W];
    merged = line;
    merged[offset*WORD_W +: WORD_W] = wdata;
  end

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back split I/D cache controller in front of a single-ported unified memory.
module cache_ctrl_wb #(
  parameter  int ADDR_W     = 16,
  parameter  int WORD_W     = 16,
  parameter  int LINE_WORDS = 4,
  parameter  int IDX_W      = 6,
  parameter  int ARB        = 0,
  parameter  int CNT_W      = 16,
  localparam int OFF_W      = cache_pkg::off_w(LINE_WORDS),
  localparam int LINE_W     = cache_pkg::line_w(WORD_W, LINE_WORDS),
  localparam int TAG_W      = cache_pkg::tag_w(ADDR_W, IDX_W, LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [ADDR_W-1:0]       i_addr,
  output logic [WORD_W-1:0]       instr,
  output logic                    i_rdy,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [WORD_W-1:0]       d_wdata,
  output logic [WORD_W-1:0]       d_rdata,
  output logic                    d_rdy,
  input  logic                    ic_hit,
  input  logic [LINE_W-1:0]       ic_line,
  output logic                    ic_we,
  output logic [LINE_W-1:0]       ic_wline,
  input  logic                    dc_hit,
  input  logic                    dc_dirty,
  input  logic [TAG_W-1:0]        dc_tag,
  input  logic [LINE_W-1:0]       dc_line,
  output logic                    dc_we,
  output logic                    dc_wdirty,
  output logic [LINE_W-1:0]       dc_wline,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [LINE_W-1:0]       mem_wline,
  input  logic [LINE_W-1:0]       mem_rline,
  input  logic                    mem_rdy,
  output logic [CNT_W-1:0]        i_miss_cnt,
  output logic [CNT_W-1:0]        d_miss_cnt,
  output logic [CNT_W-1:0]        wb_cnt
);
  import cache_pkg::*;

  state_t state;
  logic   last_d;

  logic              i_miss, d_req, d_miss, pick_d, pick_i;
  logic [LINE_W-1:0] i_src, d_src, i_merged, d_merged;
  logic [WORD_W-1:0] i_word, d_word;

  // Fills present the incoming memory line; otherwise the resident cache line is used
  always_comb begin
    i_src = (state == I_FILL) ? mem_rline : ic_line;
    d_src = (state == D_FILL) ? mem_rline : dc_line;
  end

  line_word #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) u_i_word (
    .line   (i_src),
    .offset (i_addr[OFF_W-1:0]),
    .wdata  ('0),
    .word   (i_word),
    .merged (i_merged)
  );

  line_word #(.WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) u_d_word (
    .line   (d_src),
    .offset (d_addr[OFF_W-1:0]),
    .wdata  (d_wdata),
    .word   (d_word),
    .merged (d_merged)
  );

  // Miss arbitration: last_d remembers which port the previous miss served
  always_comb begin
    i_miss = i_req & ~ic_hit;
    d_req  = d_rd | d_wr;
    d_miss = d_req & ~dc_hit;
    if (!i_miss)                pick_d = d_miss;
    else if (!d_miss)           pick_d = 1'b0;
    else if (ARB == ARB_IFIRST) pick_d = 1'b0;
    else if (ARB == ARB_RR)     pick_d = ~last_d;
    else                        pick_d = 1'b1;
    pick_i = i_miss & ~pick_d;
  end

  // Zero-wait hit paths and fill completion strobes
  always_comb begin
    instr     = i_word;
    d_rdata   = d_word;
    ic_wline  = mem_rline;
    i_rdy     = 1'b0;
    d_rdy     = 1'b0;
    ic_we     = 1'b0;
    dc_we     = 1'b0;
    dc_wdirty = 1'b0;
    dc_wline  = d_merged;
    unique case (state)
      IDLE: begin
        i_rdy     = ~i_req | ic_hit;
        d_rdy     = ~d_req | dc_hit;
        dc_we     = d_wr & dc_hit;
        dc_wdirty = 1'b1;
      end
      I_FILL: begin
        i_rdy = mem_rdy;
        ic_we = mem_rdy;
      end
      D_FILL: begin
        d_rdy     = mem_rdy;
        dc_we     = mem_rdy;
        dc_wdirty = d_wr;
        dc_wline  = d_wr ? d_merged : mem_rline;
      end
      default: ;
    endcase
  end

  // Controller FSM with registered memory strobes, address, writeback line and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wline  <= '0;
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
      wb_cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_i) begin
            mem_re   <= 1'b1;
            mem_addr <= i_addr[ADDR_W-1:OFF_W];
            last_d   <= 1'b0;
            state    <= I_FILL;
            if (~&i_miss_cnt) i_miss_cnt <= i_miss_cnt + CNT_W'(1);
          end else if (pick_d) begin
            last_d <= 1'b1;
            if (~&d_miss_cnt) d_miss_cnt <= d_miss_cnt + CNT_W'(1);
            if (dc_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= {dc_tag, d_addr[OFF_W+IDX_W-1:OFF_W]};
              mem_wline <= dc_line;
              state     <= D_EVICT;
              if (~&wb_cnt) wb_cnt <= wb_cnt + CNT_W'(1);
            end else begin
              mem_re   <= 1'b1;
              mem_addr <= d_addr[ADDR_W-1:OFF_W];
              state    <= D_FILL;
            end
          end
        end
        I_FILL: begin
          if (mem_rdy) begin
            mem_re <= 1'b0;
            state  <= IDLE;
          end
        end
        D_EVICT: begin
          if (mem_rdy) begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= d_addr[ADDR_W-1:OFF_W];
            state    <= D_FILL;
          end
        end
        D_FILL: begin
          if (mem_rdy) begin
            mem_re <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed self-checking bench for cache_ctrl_wb (round-robin arbitration, 2-bit counters).
module tb_cache_ctrl_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_rd, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] instr, d_rdata;
  logic        i_rdy, d_rdy;
  logic        ic_hit, dc_hit, dc_dirty;
  logic [63:0] ic_line, dc_line, ic_wline, dc_wline, mem_wline, mem_rline;
  logic        ic_we, dc_we, dc_wdirty;
  logic [7:0]  dc_tag;
  logic [13:0] mem_addr;
  logic        mem_re, mem_we, mem_rdy;
  logic [1:0]  i_miss_cnt, d_miss_cnt, wb_cnt;

  int checks = 0;
  int errors = 0;

  cache_ctrl_wb #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(4), .IDX_W(6), .ARB(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .instr(instr), .i_rdy(i_rdy),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rdy(d_rdy),
    .ic_hit(ic_hit), .ic_line(ic_line), .ic_we(ic_we), .ic_wline(ic_wline),
    .dc_hit(dc_hit), .dc_dirty(dc_dirty), .dc_tag(dc_tag), .dc_line(dc_line),
    .dc_we(dc_we), .dc_wdirty(dc_wdirty), .dc_wline(dc_wline),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_rdy(mem_rdy),
    .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps through a memory access of lat cycles; mem_rdy is raised in cycle lat and the
  // caller inspects the completion outputs before the next edge.
  task automatic mem_cycle(input int lat, input logic [63:0] rline,
                           input logic exp_re, input logic exp_we, input logic [13:0] exp_addr);
    for (int c = 1; c <= lat; c++) begin
      tick();
      mem_rdy   = (c == lat);
      mem_rline = rline;
      #1;
      check("mem_re", mem_re, exp_re);
      check("mem_we", mem_we, exp_we);
      check("mem_addr", mem_addr, exp_addr);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_rd = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    ic_hit = 0; dc_hit = 0; dc_dirty = 0; dc_tag = '0;
    ic_line = '0; dc_line = '0; mem_rline = '0; mem_rdy = 0;
    tick(); tick();
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wline", mem_wline, 0);
    check("rst_cnt", {i_miss_cnt, d_miss_cnt, wb_cnt}, 0);
    rst = 0;

    // Read hit
    d_rd = 1; d_addr = 16'h0042; dc_hit = 1; dc_line = 64'h4444_BEEF_2222_1111;
    #1;
    check("rdhit_data", d_rdata, 16'hBEEF);
    check("rdhit_rdy", d_rdy, 1);
    check("rdhit_dc_we", dc_we, 0);
    tick();
    check("rdhit_no_strobe", {mem_re, mem_we}, 0);
    d_rd = 0;

    // Write hit to word 1
    d_wr = 1; d_addr = 16'h0041; d_wdata = 16'h1234;
    #1;
    check("wrhit_we", dc_we, 1);
    check("wrhit_dirty", dc_wdirty, 1);
    check("wrhit_line", dc_wline, 64'h4444_BEEF_1234_1111);
    check("wrhit_rdy", d_rdy, 1);
    tick();
    check("wrhit_no_strobe", {mem_re, mem_we}, 0);
    d_wr = 0; dc_hit = 0;

    // Stray mem_rdy in IDLE does nothing
    mem_rdy = 1;
    #1;
    check("idle_rdy_we", {ic_we, dc_we}, 0);
    tick();
    mem_rdy = 0;
    check("idle_rdy_strobe", {mem_re, mem_we}, 0);

    // Clean I miss, latency 4
    i_req = 1; i_addr = 16'h0105; ic_hit = 0;
    #1;
    check("imiss_rdy0", i_rdy, 0);
    mem_cycle(4, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0, 14'h0041);
    check("imiss_rdy", i_rdy, 1);
    check("imiss_ic_we", ic_we, 1);
    check("imiss_instr", instr, 16'hCCCC);
    check("imiss_wline", ic_wline, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    mem_rdy = 0; i_req = 0;
    #1;
    check("imiss_re_off", mem_re, 0);
    check("imiss_cnt", i_miss_cnt, 1);

    // Dirty D store miss: evict latency 3, fill latency 2
    d_wr = 1; d_addr = 16'h0013; d_wdata = 16'h5A5A;
    dc_hit = 0; dc_dirty = 1; dc_tag = 8'hA5; dc_line = 64'h1111_2222_3333_4444;
    #1;
    check("dmiss_rdy0", d_rdy, 0);
    mem_cycle(3, 64'h0, 0, 1, 14'h2944);
    check("evict_wline", mem_wline, 64'h1111_2222_3333_4444);
    check("evict_no_write", {dc_we, d_rdy}, 0);
    dc_line = 64'hDEAD_DEAD_DEAD_DEAD; dc_dirty = 0;
    mem_cycle(2, 64'h0F0F_0E0E_0D0D_0C0C, 1, 0, 14'h0004);
    check("dfill_we", dc_we, 1);
    check("dfill_dirty", dc_wdirty, 1);
    check("dfill_line", dc_wline, 64'h5A5A_0E0E_0D0D_0C0C);
    check("dfill_rdy", d_rdy, 1);
    tick();
    mem_rdy = 0; d_wr = 0;
    #1;
    check("dfill_re_off", mem_re, 0);
    check("dmiss_cnt", d_miss_cnt, 1);
    check("wb_cnt", wb_cnt, 1);

    // Round-robin arbitration after reset: D first, then I, then D again
    rst = 1;
    tick();
    rst = 0;
    i_req = 1; i_addr = 16'h0200; ic_hit = 0;
    d_rd = 1; d_addr = 16'h0301; dc_hit = 0; dc_dirty = 0;
    #1;
    check("rr_both_rdy0", {i_rdy, d_rdy}, 0);
    mem_cycle(2, 64'h9999_8888_7777_6666, 1, 0, 14'h00C0);
    check("rr_d_rdy", d_rdy, 1);
    check("rr_d_data", d_rdata, 16'h7777);
    check("rr_d_clean", {dc_we, dc_wdirty}, 2'b10);
    check("rr_d_i_wait", i_rdy, 0);
    tick();
    mem_rdy = 0; d_rd = 0;
    mem_cycle(2, 64'h5555_4444_3333_2222, 1, 0, 14'h0080);
    check("rr_i_rdy", i_rdy, 1);
    check("rr_i_instr", instr, 16'h2222);
    tick();
    mem_rdy = 0;
    i_addr = 16'h0208; d_rd = 1; d_addr = 16'h0304;
    tick();
    check("rr_second_addr", mem_addr, 14'h00C1);
    check("rr_second_re", mem_re, 1);
    mem_rdy = 1;
    #1;
    check("rr_second_d_rdy", d_rdy, 1);
    tick();
    mem_rdy = 0; d_rd = 0; i_req = 0;
    #1;
    check("rr_icnt", i_miss_cnt, 1);
    check("rr_dcnt", d_miss_cnt, 2);

    // Reset during D_EVICT
    d_rd = 1; d_addr = 16'h0013; dc_hit = 0; dc_dirty = 1; dc_tag = 8'hA5;
    tick();
    d_rd = 1;
    check("evrst_we_before", mem_we, 1);
    rst = 1; mem_rdy = 1;
    #1;
    check("evrst_no_dc_we", dc_we, 0);
    tick();
    mem_rdy = 0; d_rd = 0; dc_dirty = 0;
    #1;
    check("evrst_strobes", {mem_re, mem_we}, 0);
    check("evrst_addr", mem_addr, 0);
    check("evrst_cnt", {i_miss_cnt, d_miss_cnt, wb_cnt}, 0);
    rst = 0;
    #1;
    check("evrst_idle", {dc_we, d_rdy}, 2'b01);

    // Counter saturation: four I misses on a 2-bit counter
    for (int k = 0; k < 4; k++) begin
      i_req = 1; i_addr = 16'(k * 4); ic_hit = 0;
      mem_cycle(1, 64'h0, 1, 0, 14'(k));
      check("sat_i_rdy", i_rdy, 1);
      tick();
      mem_rdy = 0; i_req = 0;
    end
    #1;
    check("sat_icnt", i_miss_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
